// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the unified memory port arbiter
package mem_port_arbiter_pkg;

    // Widths of the internal memory request bundle; the top-level ADDR_W/DATA_W must not exceed these.
    localparam int REQ_ADDR_W = 16;
    localparam int REQ_DATA_W = 16;

    // Latency counter width; covers MEM_LAT-1 for MEM_LAT up to 7.
    localparam int CNT_W = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_e;

    typedef struct packed {
        logic                  en;
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_lat_tracker.sv
// rtl/mem_port_arbiter_lat_tracker.sv - counts down the memory latency and remembers who owns the access
module mem_port_arbiter_lat_tracker
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   gnt,
    input  owner_e gnt_owner,
    output logic   done,
    output owner_e owner
);

    logic [CNT_W-1:0] cnt;

    // A grant (including one made in a completion cycle) reloads the counter and owner;
    // otherwise the owner is released on completion or the counter keeps running down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            owner <= OWN_NONE;
        end else if (gnt) begin
            cnt   <= CNT_W'(MEM_LAT - 1);
            owner <= gnt_owner;
        end else if (done) begin
            owner <= OWN_NONE;
        end else if (owner != OWN_NONE) begin
            cnt   <= cnt - 1'b1;
        end
    end

    // The in-flight access completes in the cycle its counter has reached zero.
    always_comb begin
        done = (owner != OWN_NONE) && (cnt == '0);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for a single-port unified memory
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    input  logic              halt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    arb_state_e    state_q;
    arb_state_e    state_d;
    owner_e        owner;
    logic          done;
    logic          arb_point;
    logic          store_q;
    logic [SW-1:0] starve_q;
    mem_req_t      req;

    mem_port_arbiter_lat_tracker #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_tracker (
        .clk       (clk),
        .rst       (rst),
        .gnt       (if_gnt | d_gnt),
        .gnt_owner (if_gnt ? OWN_IF : OWN_D),
        .done      (done),
        .owner     (owner)
    );

    // Arbitrate only when idle or completing; data wins unless absent or fetch has starved.
    // Grants are gated by reset so every output reads zero while reset is held.
    always_comb begin
        arb_point = (state_q == ARB_IDLE) || done;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if (rst && arb_point) begin
            if (if_req && !halt && (!d_req || (starve_q == STARVE_TOP))) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Drive the memory straight from the winner in the grant cycle.
    always_comb begin
        req = '0;
        if (if_gnt) begin
            req.en   = 1'b1;
            req.addr = REQ_ADDR_W'(if_addr);
        end else if (d_gnt) begin
            req.en    = 1'b1;
            req.we    = d_we;
            req.addr  = REQ_ADDR_W'(d_addr);
            req.wdata = REQ_DATA_W'(d_wdata);
        end
        mem_en    = req.en;
        mem_we    = req.we;
        mem_addr  = req.addr[ADDR_W-1:0];
        mem_wdata = req.wdata[DATA_W-1:0];
    end

    // IDLE/WAIT state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A completion cycle may immediately start the next access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (if_gnt || d_gnt) state_d = ARB_WAIT;
            ARB_WAIT: if (done) state_d = (if_gnt || d_gnt) ? ARB_WAIT : ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Count data grants taken while fetch is waiting; any fetch grant or fetch idle clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else if (!if_req || if_gnt) begin
            starve_q <= '0;
        end else if (d_gnt && (starve_q != STARVE_TOP)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    // Remember whether the in-flight data access is a store so its completion returns zero data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            store_q <= 1'b0;
        end else if (if_gnt || d_gnt) begin
            store_q <= d_gnt & d_we;
        end
    end

    // Completion routing, busy and stall lines.
    always_comb begin
        if_rvalid = done && (owner == OWN_IF);
        d_rvalid  = done && (owner == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !store_q) ? mem_rdata : '0;
        busy      = (state_q == ARB_WAIT) && !done;
        if_stall  = rst && if_req && !if_gnt;
        d_stall   = rst && d_req && !d_gnt;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 3;

    typedef struct packed {
        logic        if_req;
        logic [15:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        halt;
    } in_t;

    typedef struct packed {
        logic        if_gnt;
        logic        if_rvalid;
        logic [15:0] if_rdata;
        logic        if_stall;
        logic        d_gnt;
        logic        d_rvalid;
        logic [15:0] d_rdata;
        logic        d_stall;
        logic        mem_en;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic        busy;
    } out_t;

    typedef struct packed {
        in_t  stim;
        out_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_init = 1'b1;
    in_t         in0 = '0;
    in_t         in1 = '0;
    out_t        o0;
    out_t        o1;
    logic [15:0] mem_rdata0;
    logic [15:0] mem_rdata1;
    int          checks = 0;
    int          errors = 0;

    logic [15:0] mem  [2][256];
    logic [15:0] pipe [2][8];
    out_t        cap  [2];

    // Reference model state: absolute completion time per DUT.
    logic        m_busy  [2];
    int          m_done  [2];
    int          m_own   [2];
    logic        m_we    [2];
    logic [15:0] m_data  [2];
    int          m_starve[2];
    logic        m_if_g  [2];
    logic        m_d_g   [2];
    int          cyc;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_MAX(STARVE_MAX)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(in0.if_req), .if_addr(in0.if_addr), .if_gnt(o0.if_gnt), .if_rvalid(o0.if_rvalid),
        .if_rdata(o0.if_rdata), .if_stall(o0.if_stall),
        .d_req(in0.d_req), .d_we(in0.d_we), .d_addr(in0.d_addr), .d_wdata(in0.d_wdata),
        .d_gnt(o0.d_gnt), .d_rvalid(o0.d_rvalid), .d_rdata(o0.d_rdata), .d_stall(o0.d_stall),
        .halt(in0.halt), .mem_en(o0.mem_en), .mem_we(o0.mem_we), .mem_addr(o0.mem_addr),
        .mem_wdata(o0.mem_wdata), .mem_rdata(mem_rdata0), .busy(o0.busy)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(in1.if_req), .if_addr(in1.if_addr), .if_gnt(o1.if_gnt), .if_rvalid(o1.if_rvalid),
        .if_rdata(o1.if_rdata), .if_stall(o1.if_stall),
        .d_req(in1.d_req), .d_we(in1.d_we), .d_addr(in1.d_addr), .d_wdata(in1.d_wdata),
        .d_gnt(o1.d_gnt), .d_rvalid(o1.d_rvalid), .d_rdata(o1.d_rdata), .d_stall(o1.d_stall),
        .halt(in1.halt), .mem_en(o1.mem_en), .mem_we(o1.mem_we), .mem_addr(o1.mem_addr),
        .mem_wdata(o1.mem_wdata), .mem_rdata(mem_rdata1), .busy(o1.busy)
    );

    function automatic logic [15:0] pat(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a, ~a};
    endfunction

    // Memory requests are captured mid-cycle and applied on the following rising edge.
    always @(negedge clk) begin
        cap[0] <= o0;
        cap[1] <= o1;
    end

    // Behavioural single-port memory with a read pipeline per DUT.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_init) begin
                for (int a = 0; a < 256; a++) mem[d][a] <= pat(8'(a));
            end else if (cap[d].mem_en && cap[d].mem_we) begin
                mem[d][cap[d].mem_addr[7:0]] <= cap[d].mem_wdata;
            end
            for (int i = 7; i > 0; i--) pipe[d][i] <= pipe[d][i-1];
            pipe[d][0] <= (cap[d].mem_en && !cap[d].mem_we) ? mem[d][cap[d].mem_addr[7:0]] : 16'hDEAD;
        end
    end

    assign mem_rdata0 = pipe[0][1];
    assign mem_rdata1 = pipe[1][0];

    function automatic in_t mk_in(input logic ir, input logic [15:0] ia, input logic dr, dw,
                                  input logic [15:0] da, dwd, input logic h);
        in_t s;
        s = '{if_req: ir, if_addr: ia, d_req: dr, d_we: dw, d_addr: da, d_wdata: dwd, halt: h};
        return s;
    endfunction

    function automatic out_t mk_out(input logic ig, irv, input logic [15:0] ird, input logic ist, dg, drv,
                                    input logic [15:0] drd, input logic dst, en, we,
                                    input logic [15:0] ad, wd, input logic bz);
        out_t e;
        e = '{if_gnt: ig, if_rvalid: irv, if_rdata: ird, if_stall: ist, d_gnt: dg, d_rvalid: drv,
              d_rdata: drd, d_stall: dst, mem_en: en, mem_we: we, mem_addr: ad, mem_wdata: wd, busy: bz};
        return e;
    endfunction

    task automatic chk_out(input string name, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0; m_done[d] = 0; m_own[d] = 0; m_we[d] = 1'b0;
            m_data[d] = '0; m_starve[d] = 0; m_if_g[d] = 1'b0; m_d_g[d] = 1'b0;
        end
        cyc = 0;
    endtask

    // One cycle of the reference model for DUT d, compared against its outputs.
    task automatic model_step(input int d);
        in_t  s;
        out_t a;
        out_t e;
        logic comp;
        logic arb;
        s = (d == 0) ? in0 : in1;
        a = (d == 0) ? o0 : o1;
        e = '0;
        comp = m_busy[d] && (cyc == m_done[d]);
        arb  = !m_busy[d] || comp;
        if (comp && m_own[d] == 1) begin
            e.if_rvalid = 1'b1;
            e.if_rdata  = m_data[d];
        end
        if (comp && m_own[d] == 2) begin
            e.d_rvalid = 1'b1;
            e.d_rdata  = m_we[d] ? 16'h0 : m_data[d];
        end
        e.if_gnt = arb && s.if_req && !s.halt && (!s.d_req || m_starve[d] == STARVE_MAX);
        e.d_gnt  = arb && s.d_req && !e.if_gnt;
        if (e.if_gnt) begin
            e.mem_en   = 1'b1;
            e.mem_addr = s.if_addr;
        end else if (e.d_gnt) begin
            e.mem_en    = 1'b1;
            e.mem_we    = s.d_we;
            e.mem_addr  = s.d_addr;
            e.mem_wdata = s.d_wdata;
        end
        e.if_stall = s.if_req && !e.if_gnt;
        e.d_stall  = s.d_req && !e.d_gnt;
        e.busy     = m_busy[d] && !comp;
        chk_out($sformatf("rand_dut%0d_cyc%0d", d, cyc), a, e);
        if (e.if_gnt || e.d_gnt) begin
            m_busy[d] = 1'b1;
            m_done[d] = cyc + ((d == 0) ? 2 : 1);
            m_own[d]  = e.if_gnt ? 1 : 2;
            m_we[d]   = e.d_gnt && s.d_we;
            m_data[d] = mem[d][e.mem_addr[7:0]];
        end else if (comp) begin
            m_busy[d] = 1'b0;
        end
        if (!s.if_req || e.if_gnt) m_starve[d] = 0;
        else if (e.d_gnt && m_starve[d] < STARVE_MAX) m_starve[d] = m_starve[d] + 1;
        m_if_g[d] = e.if_gnt;
        m_d_g[d]  = e.d_gnt;
    endtask

    function automatic in_t rand_drive(input in_t cur, input logic ig, input logic dg);
        in_t s;
        s = cur;
        if (!s.if_req || ig) begin
            s.if_req  = ($urandom_range(0, 2) != 0);
            s.if_addr = {8'h00, 8'($urandom)};
        end
        if (!s.d_req || dg) begin
            s.d_req   = ($urandom_range(0, 2) != 0);
            s.d_we    = 1'($urandom);
            s.d_addr  = {8'h00, 8'($urandom)};
            s.d_wdata = 16'($urandom);
        end
        s.halt = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    initial begin
        vec_t        vq[$];
        in_t         idle;
        in_t         both;
        out_t        e;
        int          prev;
        int          dg_cnt;
        int          rv_seen;
        logic [15:0] prev_addr;

        idle = '0;

        // Reset state: requests asserted while in reset must not leak through.
        in0 = mk_in(1, 16'h0010, 1, 1, 16'h0020, 16'h1234, 0);
        tick();
        mem_init = 1'b0;
        @(negedge clk);
        chk_out("reset_outputs_dut0", o0, '0);
        chk_out("reset_outputs_dut1", o1, '0);
        tick();
        in0 = idle;
        rst = 1'b1;

        // Single fetch, then store followed by load of the same word.
        vq.push_back('{mk_in(1, 16'h0010, 0, 0, 0, 0, 0), mk_out(1,0,0,0, 0,0,0,0, 1,0,16'h0010,0, 0)});
        vq.push_back('{idle,                              mk_out(0,0,0,0, 0,0,0,0, 0,0,0,0, 1)});
        vq.push_back('{idle,                              mk_out(0,1,16'hBEEF,0, 0,0,0,0, 0,0,0,0, 0)});
        vq.push_back('{mk_in(0, 0, 1, 1, 16'h0020, 16'h1234, 0), mk_out(0,0,0,0, 1,0,0,0, 1,1,16'h0020,16'h1234, 0)});
        vq.push_back('{mk_in(0, 0, 1, 0, 16'h0020, 0, 0), mk_out(0,0,0,0, 0,0,0,1, 0,0,0,0, 1)});
        vq.push_back('{mk_in(0, 0, 1, 0, 16'h0020, 0, 0), mk_out(0,0,0,0, 1,1,0,0, 1,0,16'h0020,0, 0)});
        vq.push_back('{idle,                              mk_out(0,0,0,0, 0,0,0,0, 0,0,0,0, 1)});
        vq.push_back('{idle,                              mk_out(0,0,0,0, 0,1,16'h1234,0, 0,0,0,0, 0)});

        // Contention: both held, expected grant order D,D,D,IF repeating.
        both = mk_in(1, 16'h0030, 1, 0, 16'h0040, 0, 0);
        prev = 0;
        for (int g = 0; g < 8; g++) begin
            e = '0;
            if (prev == 1) begin e.if_rvalid = 1'b1; e.if_rdata = pat(8'h30); end
            if (prev == 2) begin e.d_rvalid = 1'b1; e.d_rdata = pat(8'h40); end
            e.mem_en = 1'b1;
            if ((g % 4) == 3) begin
                e.if_gnt = 1'b1; e.d_stall = 1'b1; e.mem_addr = 16'h0030; prev = 1;
            end else begin
                e.d_gnt = 1'b1; e.if_stall = 1'b1; e.mem_addr = 16'h0040; prev = 2;
            end
            vq.push_back('{both, e});
            vq.push_back('{both, mk_out(0,0,0,1, 0,0,0,1, 0,0,0,0, 1)});
        end
        vq.push_back('{idle, mk_out(0,1,pat(8'h30),0, 0,0,0,0, 0,0,0,0, 0)});

        for (int i = 0; i < vq.size(); i++) begin
            tick();
            in0 = vq[i].stim;
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), o0, vq[i].exp);
        end

        // Halt: fetch must never be granted while data keeps being served.
        tick();
        in0 = mk_in(1, 16'h0050, 1, 0, 16'h0060, 0, 1);
        dg_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            chk($sformatf("halt_if_gnt_%0d", i), 32'(o0.if_gnt), 32'd0);
            if (o0.d_gnt) dg_cnt++;
        end
        chk("halt_d_grants", dg_cnt, 5);
        tick();
        in0.halt = 1'b0;
        @(negedge clk);
        chk("halt_release_if_gnt", {o0.if_gnt, o0.d_gnt, o0.mem_addr}, {1'b1, 1'b0, 16'h0050});
        tick();
        in0 = idle;
        for (int i = 0; i < 3; i++) tick();

        // Reset in the middle of a load: outputs clear at once and no completion follows.
        in0 = mk_in(0, 0, 1, 0, 16'h0040, 0, 0);
        @(negedge clk);
        chk("rst_mid_load_gnt", 32'(o0.d_gnt), 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_out("rst_mid_outputs", o0, '0);
        tick();
        rst = 1'b1;
        in0 = idle;
        rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            if (o0.d_rvalid || o0.if_rvalid || o0.busy) rv_seen++;
        end
        chk("rst_no_rvalid", rv_seen, 0);
        tick();
        in0 = mk_in(1, 16'h0011, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_after_if_gnt", {o0.if_gnt, o0.mem_en, o0.mem_addr}, {1'b1, 1'b1, 16'h0011});
        tick();
        in0 = idle;
        @(negedge clk);
        chk("rst_after_busy", 32'(o0.busy), 32'd1);
        tick();
        @(negedge clk);
        chk("rst_after_rvalid", {o0.if_rvalid, o0.if_rdata}, {1'b1, 16'h11EE});

        // MEM_LAT=1: alternate fetch/load every cycle on the second instance.
        prev = 0;
        prev_addr = '0;
        for (int k = 0; k <= 10; k++) begin
            tick();
            if (k == 10) in1 = idle;
            else if ((k % 2) == 0) in1 = mk_in(1, 16'h0070 + 16'(k), 0, 0, 0, 0, 0);
            else in1 = mk_in(0, 0, 1, 0, 16'h0080 + 16'(k), 0, 0);
            e = '0;
            if (prev == 1) begin e.if_rvalid = 1'b1; e.if_rdata = pat(prev_addr[7:0]); end
            if (prev == 2) begin e.d_rvalid = 1'b1; e.d_rdata = pat(prev_addr[7:0]); end
            if (k < 10) begin
                e.mem_en = 1'b1;
                if ((k % 2) == 0) begin
                    e.if_gnt = 1'b1; prev = 1; prev_addr = 16'h0070 + 16'(k);
                end else begin
                    e.d_gnt = 1'b1; prev = 2; prev_addr = 16'h0080 + 16'(k);
                end
                e.mem_addr = prev_addr;
            end
            @(negedge clk);
            chk_out($sformatf("lat1_k%0d", k), o1, e);
        end

        // Randomized traffic on both instances against the reference model.
        tick();
        rst = 1'b0;
        in0 = idle;
        in1 = idle;
        tick();
        rst = 1'b1;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            if (n > 0) tick();
            in0 = rand_drive(in0, m_if_g[0], m_d_g[0]);
            in1 = rand_drive(in1, m_if_g[1], m_d_g[1]);
            @(negedge clk);
            model_step(0);
            model_step(1);
            cyc++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
